// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Multiplies use 32-step shift-add and divides use 32-step restoring division,
// both on operand magnitudes. The sign is fixed up in the DONE state, and the
// writeback is registered on the way out of DONE.
// Optional macro MULDIV_FAST_MUL_EN: multiplies skip the iterative path and use
// a combinational 32x32 product formed in the DONE state.
module muldiv_unit #(
  parameter int RD_W  = 5,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [31:0]     op_a,
  input  logic [31:0]     op_b,
  input  logic [RD_W-1:0] rd_in,
  output logic            busy,
  output logic            done,
  output logic            wb_we,
  output logic [RD_W-1:0] wb_rd,
  output logic [31:0]     wb_data
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e             state_q, state_d;
  logic [63:0]        acc_q, acc_d;      // {hi/rem, lo/multiplier/quotient}
  logic [31:0]        opb_q, opb_d;      // multiplicand or divisor magnitude
  logic [2:0]         f3_q, f3_d;
  logic [RD_W-1:0]    rd_q, rd_d;
  logic               qneg_q, qneg_d;    // product / quotient sign
  logic               rneg_q, rneg_d;    // remainder sign
  logic               spec_q, spec_d;    // acc already holds the final raw result
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               we_q, we_d;
  logic [RD_W-1:0]    wb_rd_q, wb_rd_d;
  logic [31:0]        wb_data_q, wb_data_d;

  // Operand decode at request time
  logic        is_div, a_signed, b_signed, sa, sb, div0, ovf;
  logic [31:0] mag_a, mag_b;
  // Iteration and result datapath
  logic [32:0] mul_sum, div_part, div_diff;
  logic [63:0] mul_mag, prod;
  logic [31:0] quo, rem, result;

  assign is_div   = funct3[2];
  assign a_signed = is_div ? ~funct3[0] : (funct3[1:0] == 2'd1 || funct3[1:0] == 2'd2);
  assign b_signed = is_div ? ~funct3[0] : (funct3[1:0] == 2'd1);
  assign sa       = a_signed & op_a[31];
  assign sb       = b_signed & op_b[31];
  assign mag_a    = sa ? -op_a : op_a;
  assign mag_b    = sb ? -op_b : op_b;
  assign div0     = is_div && (op_b == 32'd0);
  assign ovf      = is_div && !funct3[0] && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);

  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
  assign div_part = acc_q[63:31];
  assign div_diff = div_part - {1'b0, opb_q};

`ifdef MULDIV_FAST_MUL_EN
  assign mul_mag  = 64'(acc_q[31:0]) * 64'(opb_q);
`else
  assign mul_mag  = acc_q;
`endif
  assign prod     = qneg_q ? -mul_mag : mul_mag;
  assign quo      = spec_q ? acc_q[31:0]  : (qneg_q ? -acc_q[31:0]  : acc_q[31:0]);
  assign rem      = spec_q ? acc_q[63:32] : (rneg_q ? -acc_q[63:32] : acc_q[63:32]);

  // Final result selection by op
  always_comb begin
    result = 32'd0;
    if (f3_q[2])               result = f3_q[1] ? rem : quo;
    else if (f3_q[1:0] == 2'd0) result = prod[31:0];
    else                        result = prod[63:32];
  end

  // Next-state, datapath step and writeback
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    spec_d    = spec_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    we_d      = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          f3_d   = funct3;
          rd_d   = rd_in;
          qneg_d = sa ^ sb;
          rneg_d = sa;
          cnt_d  = '0;
          opb_d  = mag_b;
          if (div0) begin
            acc_d   = {op_a, 32'hFFFF_FFFF};
            spec_d  = 1'b1;
            state_d = DONE;
          end else if (ovf) begin
            acc_d   = {32'd0, 32'h8000_0000};
            spec_d  = 1'b1;
            state_d = DONE;
          end else begin
            // Same initial layout for both: zero high half, |a| in the low half
            acc_d   = {32'd0, mag_a};
            spec_d  = 1'b0;
            state_d = CALC;
`ifdef MULDIV_FAST_MUL_EN
            if (!is_div) state_d = DONE;
`endif
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (f3_q[2]) begin
          if (!div_diff[32]) acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
          else               acc_d = {div_part[31:0], acc_q[30:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
        end
        if (cnt_q == CNT_W'(31)) state_d = DONE;
      end
      DONE: begin
        done_d    = 1'b1;
        we_d      = (rd_q != '0);
        wb_rd_d   = rd_q;
        wb_data_d = result;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over everything: no writeback, outputs keep old values
    if (flush) begin
      state_d   = IDLE;
      done_d    = 1'b0;
      we_d      = 1'b0;
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath and writeback registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      opb_q     <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      spec_q    <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      f3_q      <= f3_d;
      rd_q      <= rd_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      spec_q    <= spec_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      we_q      <= we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign wb_we   = we_q;
  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a queue scoreboard of expected writebacks.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int ML = 2;
`else
  localparam int ML = 34;
`endif
  localparam int DL = 34;
  localparam int SL = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        busy, done, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_data = 32'd0;
  logic [4:0]  last_rd = 5'd0;

  muldiv_unit #(.RD_W(5), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .busy(busy), .done(done),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait (bounded) for done, then score it.
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] expd,
                       input int exp_lat, input bit glitch);
    int   lat;
    int   bcnt;
    exp_t e;
    sb.push_back('{rd: rd, data: expd});
    funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      if (glitch && lat == 10) begin
        start = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3; rd_in = 5'd9;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    check({tag, ".done"}, done, 1'b1);
    if (done) begin
      e = sb.pop_front();
      check({tag, ".lat"}, lat, exp_lat);
      check({tag, ".data"}, wb_data, e.data);
      check({tag, ".rd"}, wb_rd, e.rd);
      check({tag, ".we"}, wb_we, e.rd != 5'd0);
      check({tag, ".busy_cycles"}, bcnt, exp_lat - 1);
      check({tag, ".busy_at_done"}, busy, 1'b0);
      last_data = e.data;
      last_rd   = e.rd;
    end
    @(posedge clk); #1;
    check({tag, ".pulse"}, done, 1'b0);
  endtask

  initial begin
    int ndone;
    // Reset values
    #1 rst_n = 1'b0;
    #10;
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.we", wb_we, 1'b0);
    check("rst.rd", wb_rd, 5'd0);
    check("rst.data", wb_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Multiplies
    do_op("mul",    3'd0, 32'd7,        32'd6,        5'd5, 32'd42,        ML, 1'b0);
    do_op("mulh",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'h00000000,  ML, 1'b0);
    do_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE,  ML, 1'b0);
    do_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2,        5'd3, 32'hFFFFFFFF,  ML, 1'b0);
    do_op("mulh2",  3'd1, 32'h80000000, 32'h80000000, 5'd17, 32'h40000000, ML, 1'b0);
    do_op("mulneg", 3'd0, 32'hFFFFFFFD, 32'd5,        5'd18, 32'hFFFFFFF1, ML, 1'b0);

    // Divides
    do_op("div",  3'd4, 32'hFFFFFFF9, 32'd2, 5'd4, 32'hFFFFFFFD, DL, 1'b0);
    do_op("rem",  3'd6, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, DL, 1'b0);
    do_op("divu", 3'd5, 32'd100,      32'd7, 5'd7, 32'd14,       DL, 1'b0);
    do_op("remu", 3'd7, 32'd100,      32'd7, 5'd8, 32'd2,        DL, 1'b0);

    // Special cases
    do_op("divu0", 3'd5, 32'h1234,     32'd0,        5'd10, 32'hFFFFFFFF, SL, 1'b0);
    do_op("rem0",  3'd6, 32'h1234,     32'd0,        5'd19, 32'h1234,     SL, 1'b0);
    do_op("remov", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'd0,        SL, 1'b0);
    do_op("divov", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'h80000000, SL, 1'b0);

    // rd=0 with a start pulse mid-CALC that must be ignored
    do_op("div_rd0", 3'd4, 32'd20, 32'd3, 5'd0, 32'd6, DL, 1'b1);

    // Flush mid-operation
    funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd12; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush.busy", busy, 1'b0);
    ndone = 0;
    repeat (40) begin
      if (done || wb_we) ndone++;
      @(posedge clk); #1;
    end
    check("flush.no_done", ndone, 0);
    check("flush.data_held", wb_data, last_data);
    check("flush.rd_held", wb_rd, last_rd);

    // Reset mid-CALC
    funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd10; rd_in = 5'd13; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("rstmid.busy", busy, 1'b0);
    check("rstmid.done", done, 1'b0);
    check("rstmid.data", wb_data, 32'd0);
    check("rstmid.rd", wb_rd, 5'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("post_mulhu", 3'd3, 32'h80000000, 32'd4, 5'd14, 32'd2,        ML, 1'b0);
    do_op("post_div",   3'd4, 32'hFFFFFF9C, 32'd7, 5'd15, 32'hFFFFFFF2, DL, 1'b0);
    do_op("post_rem",   3'd6, 32'hFFFFFF9C, 32'd7, 5'd16, 32'hFFFFFFFE, DL, 1'b0);

    check("sb.empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit. It sits between the register file read ports and the register file write port.
- Consumes rs1/rs2 operand data plus the destination index. Produces a one-cycle writeback (we/rd/rd_data) into the register file when the result is ready.
- Stalls the core via busy for the duration of the operation.

Parameters:
- RD_W, 5, width of destination register index; must match the register file rd port.
- CNT_W, 6, iteration counter width; must hold the value 32.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- flush  input  1  abort in-flight operation; no writeback.
- funct3  input  3  op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op_a  input  32  rs1_data.
- op_b  input  32  rs2_data.
- rd_in  input  RD_W  destination index.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle completion pulse.
- wb_we  output  1  done & (wb_rd != 0).
- wb_rd  output  RD_W  latched destination index.
- wb_data  output  32  result; holds its value until the next done.

Behaviour:
- Reset: asynchronous, active-low, rst_n; clock clk. All state clears to IDLE.
  - busy, done, wb_we = 0.
  - wb_rd = 0, wb_data = 0.
  - Internal accumulator and counter = 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 at edge k: latch funct3, rd_in, op_a, op_b; determine signs.
  - Special case (divide op and op_b==0, or signed DIV/REM with op_a==0x80000000 and op_b==0xFFFFFFFF): next state DONE.
  - Otherwise: next state CALC, counter=0.
- CALC:
  - One iteration per cycle, 32 iterations total (edges k+1..k+32).
  - Busy is high from edge k.
  - After the iteration with counter==31, next state DONE.
- DONE:
  - done=1 and wb_we as defined for exactly one cycle.
  - wb_data valid in the same cycle; next state IDLE.
  - Normal ops: done is high during the cycle after edge k+33, i.e. 34-cycle latency.
  - Special cases: done is high after edge k+1.
- Back-to-back: start may be asserted in the DONE cycle; it is ignored. It is accepted only in IDLE.
- start while busy: ignored, no side effects.
- flush=1 in any state: next state IDLE at the following edge.
  - No done, no wb_we.
  - wb_data and wb_rd retain their previous values.
  - flush takes priority over start in IDLE.
- Multiply:
  - Operands are converted to magnitudes per signedness: MULH both signed; MULHSU a signed, b unsigned; MUL/MULHU unsigned.
  - Shift-add over 32 cycles produces a 64-bit product, negated if the result sign is negative.
  - MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- Divide:
  - Restoring division on magnitudes (signed for DIV/REM, raw for DIVU/REMU), one quotient bit per cycle.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- Special results:
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = op_a.
  - Signed overflow: quotient = 0x80000000, remainder = 0.
- Reset mid-operation: immediate return to the reset values; no writeback.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined:
  - Multiply ops (funct3 0-3) compute the 64-bit product combinationally from the latched operands and go IDLE -> DONE.
  - done is high after edge k+1, giving 2-cycle latency.
  - Divides are unchanged.
- Undefined: all multiplies use the 32-cycle iterative path. No hardware multiplier is inferred.

Test Plan:
- Reset release, then MUL, a=7, b=6, rd=5 -> done exactly 34 cycles after start; wb_we=1, wb_rd=5, wb_data=42; busy high for 33 cycles. (With MULDIV_FAST_MUL_EN: done 2 cycles after start.)
- MULH, a=0xFFFFFFFF, b=0xFFFFFFFF -> 0x00000000. MULHU same operands -> 0xFFFFFFFE. MULHSU, a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV, a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU, a=100, b=7 -> 14. REMU same operands -> 2.
- DIVU, a=0x1234, b=0 -> 0xFFFFFFFF after 2 cycles. REM, a=0x80000000, b=0xFFFFFFFF -> 0 after 2 cycles.
- DIV with rd=0 -> done=1, wb_we=0. start pulsed mid-CALC -> ignored, the original result is unaffected.
- Start DIVU, then flush at cycle 10 -> no done within the next 40 cycles; wb_data unchanged. rst_n low mid-CALC -> busy=0 immediately; a new op after release completes correctly.
